vc_pop_scheduler: RTL

- Registered pop-request controller for the PCIe transaction datapath.
- Drives pop of the main FIFO, which feeds the vc_id demux, and of the VC0/VC1 FIFOs, which feed the mux and the D0/D1 demux.
- Shares the single mux path between VC0 and VC1 with weighted round robin, and honours back-pressure from the VC and destination FIFO pause flags.
- Gated by the control FSM's active state.

---
 rtl/vc_pop_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/vc_pop_scheduler.sv
// Registered pop-request controller: main-FIFO pop plus a weighted round-robin
// VC0/VC1 scheduler that shares the mux path, with pause/stall back-pressure.
module vc_pop_scheduler #(
    parameter int            WW     = 4,
    parameter logic [WW-1:0] W0_DEF = WW'(4),
    parameter logic [WW-1:0] W1_DEF = WW'(1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          cfg_load,
    input  logic [WW-1:0] w0_in,
    input  logic [WW-1:0] w1_in,
    input  logic          mf_empty,
    input  logic          mf_almost_empty,
    input  logic          vc0_pause,
    input  logic          vc1_pause,
    input  logic          vc0_empty,
    input  logic          vc1_empty,
    input  logic          vc0_almost_empty,
    input  logic          vc1_almost_empty,
    input  logic          d0_pause,
    input  logic          d1_pause,
    output logic          pop_mf,
    output logic          pop_vc0,
    output logic          pop_vc1,
    output logic          grant,
    output logic [1:0]    sched_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, SERVE0 = 2'd1, SERVE1 = 2'd2, PAUSE = 2'd3} state_t;

    function automatic logic [WW-1:0] nz(input logic [WW-1:0] w);
        return (w == '0) ? WW'(1) : w;
    endfunction

    state_t        state_q, state_d;
    logic [WW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] w0_q, w1_q, w0_sh_q, w1_sh_q;
    logic          rptr_q, rptr_d;
    logic          pop_mf_q, pop_mf_d, pop_vc0_q, pop_vc0_d, pop_vc1_q, pop_vc1_d;
    logic          grant_q, grant_d;

    logic          stall, go, vc0_ok, vc1_ok, sel_vc, cur_ok, oth_ok, serving;
    logic [WW-1:0] wlim;
    state_t        st_cur, st_oth;

    assign stall   = d0_pause | d1_pause;
    assign go      = enable & ~stall;
    assign vc0_ok  = ~vc0_empty & ~(pop_vc0_q & vc0_almost_empty);
    assign vc1_ok  = ~vc1_empty & ~(pop_vc1_q & vc1_almost_empty);
    assign serving = (state_q == SERVE0) || (state_q == SERVE1);
    // In PAUSE the "current" VC is the resume pointer; otherwise it is the served VC.
    assign sel_vc  = (state_q == PAUSE) ? rptr_q : state_q[1];
    assign cur_ok  = sel_vc ? vc1_ok : vc0_ok;
    assign oth_ok  = sel_vc ? vc0_ok : vc1_ok;
    assign st_cur  = sel_vc ? SERVE1 : SERVE0;
    assign st_oth  = sel_vc ? SERVE0 : SERVE1;
    // At a turn boundary the pending (shadow) weight applies immediately.
    assign wlim    = (cnt_q == '0) ? (sel_vc ? w1_sh_q : w0_sh_q)
                                   : (sel_vc ? w1_q    : w0_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rptr_q    <= 1'b0;
            w0_q      <= nz(W0_DEF);
            w1_q      <= nz(W1_DEF);
            w0_sh_q   <= nz(W0_DEF);
            w1_sh_q   <= nz(W1_DEF);
            pop_mf_q  <= 1'b0;
            pop_vc0_q <= 1'b0;
            pop_vc1_q <= 1'b0;
            grant_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rptr_q    <= rptr_d;
            pop_mf_q  <= pop_mf_d;
            pop_vc0_q <= pop_vc0_d;
            pop_vc1_q <= pop_vc1_d;
            grant_q   <= grant_d;
            if (cnt_q == '0) begin
                w0_q <= w0_sh_q;
                w1_q <= w1_sh_q;
            end
            if (cfg_load) begin
                w0_sh_q <= nz(w0_in);
                w1_sh_q <= nz(w1_in);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rptr_d  = rptr_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    if (vc0_ok)      state_d = SERVE0;
                    else if (vc1_ok) state_d = SERVE1;
                end
            end
            SERVE0, SERVE1: begin
                if (!go) begin
                    state_d = PAUSE;
                    rptr_d  = sel_vc;
                end else if (cur_ok) begin
                    if (cnt_q == wlim - 1'b1) begin
                        cnt_d = '0;
                        if (oth_ok) state_d = st_oth;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = oth_ok ? st_oth : IDLE;
                end
            end
            PAUSE: begin
                if (go) begin
                    if (cur_ok) begin
                        state_d = st_cur;
                    end else begin
                        cnt_d   = '0;
                        state_d = oth_ok ? st_oth : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop_vc0_d = 1'b0;
        pop_vc1_d = 1'b0;
        grant_d   = grant_q;
        if (serving && go && cur_ok) begin
            pop_vc0_d = ~sel_vc;
            pop_vc1_d = sel_vc;
            grant_d   = sel_vc;
        end
        pop_mf_d = enable & ~mf_empty & ~vc0_pause & ~vc1_pause & ~(pop_mf_q & mf_almost_empty);
    end

    assign pop_mf      = pop_mf_q;
    assign pop_vc0     = pop_vc0_q;
    assign pop_vc1     = pop_vc1_q;
    assign grant       = grant_q;
    assign sched_state = state_q;

endmodule
